// File: rtl/mempool_pkg.sv
// Shared types and constants for the MemPool wake-up unit.
// Build option: MEMPOOL_WAKE_UP_COUNTER_EN chooses multi-bit pending counters
// instead of one coalescing pending bit per core (see mempool_wake_up_core).
package mempool_pkg;

  localparam int unsigned NumCoresPerTile = 4;
  localparam int unsigned NumGroups       = 4;

  // Wide enough for any core, tile or group index of a realistic cluster.
  localparam int unsigned ReqIdWidth      = 16;

  typedef enum logic [1:0] {
    WakeCore  = 2'd0,
    WakeTile  = 2'd1,
    WakeGroup = 2'd2,
    WakeAll   = 2'd3
  } wake_mode_e;

  typedef struct packed {
    wake_mode_e              mode;
    logic [ReqIdWidth-1:0]   id;
  } wake_req_t;

  typedef enum logic [1:0] {
    CoreIdle  = 2'd0,
    CorePulse = 2'd1,
    CoreWait  = 2'd2
  } core_state_e;

endpackage

// File: rtl/mempool_wake_up_core.sv
// Per-core wake-up slice: pending counter, wake FSM and registered pulse.
// Build option: MEMPOOL_WAKE_UP_COUNTER_EN defined gives a PendWidth-bit
// counter with a sticky overflow flag; undefined gives a single pending bit
// where repeated wakes coalesce and overflow stays 0.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// CoreIdle  | no pulse in flight; pulse when pending and core sits in WFI
// CorePulse | wake_up_o high for this one cycle; one pending wake consumed
// CoreWait  | pulse delivered; wait for the core to leave WFI before rearming
module mempool_wake_up_core
  import mempool_pkg::*;
#(
  parameter int unsigned PendWidth = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic wfi_i,
  output logic wake_up_o,
  output logic overflow_o
);

`ifdef MEMPOOL_WAKE_UP_COUNTER_EN
  localparam bit CounterEn = 1'b1;
`else
  localparam bit CounterEn = 1'b0;
`endif

  localparam int unsigned CntWidth = CounterEn ? PendWidth : 1;
  localparam logic [CntWidth-1:0] PendMax = '1;

  core_state_e         state_q;
  logic [CntWidth-1:0] pend_q;
  logic                wake_q;
  logic                ovf_q;
  logic                dec;
  logic                sat;

  // The pulse cycle is the one that consumes a pending wake.
  assign dec = (state_q == CorePulse);
  assign sat = inc_i && !dec && (pend_q == PendMax);

  // FSM, pending counter and sticky overflow, all registered.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= CoreIdle;
      pend_q  <= '0;
      wake_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        CoreIdle: begin
          if ((pend_q != '0) && wfi_i) begin
            state_q <= CorePulse;
            wake_q  <= 1'b1;
          end
        end
        CorePulse: begin
          state_q <= CoreWait;
          wake_q  <= 1'b0;
        end
        CoreWait: begin
          if (!wfi_i) state_q <= CoreIdle;
        end
        default: begin
          state_q <= CoreIdle;
          wake_q  <= 1'b0;
        end
      endcase

      if (inc_i && !dec) begin
        if (pend_q != PendMax) pend_q <= pend_q + 1'b1;
      end else if (dec && !inc_i) begin
        pend_q <= pend_q - 1'b1;
      end

      if (CounterEn && sat) ovf_q <= 1'b1;
    end
  end

  assign wake_up_o  = wake_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/mempool_wake_up_unit.sv
// MemPool cluster wake-up unit: decodes software wake requests into a core
// mask, merges it with the external wake lines and feeds one
// mempool_wake_up_core per core. Overflow is the OR of all cores.
// Build option: MEMPOOL_WAKE_UP_COUNTER_EN (counter vs single pending bit).
module mempool_wake_up_unit #(
  parameter int unsigned NumCores        = 256,
  parameter int unsigned NumCoresPerTile = mempool_pkg::NumCoresPerTile,
  parameter int unsigned NumGroups       = mempool_pkg::NumGroups,
  parameter int unsigned PendWidth       = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumCores-1:0]         wake_up_i,
  input  logic                        wake_req_valid_i,
  output logic                        wake_req_ready_o,
  input  logic [1:0]                  wake_req_mode_i,
  input  logic [$clog2(NumCores)-1:0] wake_req_id_i,
  input  logic [NumCores-1:0]         core_wfi_i,
  output logic [NumCores-1:0]         wake_up_o,
  output logic                        overflow_o
);
  import mempool_pkg::*;

  localparam int unsigned CoresPerGroup = NumCores / NumGroups;

  wake_req_t           req;
  logic                ready_q;
  logic                fire;
  logic [NumCores-1:0] sel;
  logic [NumCores-1:0] inc;
  logic [NumCores-1:0] ovf;

  assign req.mode = wake_mode_e'(wake_req_mode_i);
  assign req.id   = ReqIdWidth'(wake_req_id_i);
  assign fire     = wake_req_valid_i & ready_q;

  // Target mask; an index past the last core/tile/group simply matches nothing.
  always_comb begin
    sel = '0;
    if (fire) begin
      for (int unsigned c = 0; c < NumCores; c++) begin
        case (req.mode)
          WakeCore:  sel[c] = (req.id == ReqIdWidth'(c));
          WakeTile:  sel[c] = (req.id == ReqIdWidth'(c / NumCoresPerTile));
          WakeGroup: sel[c] = (req.id == ReqIdWidth'(c / CoresPerGroup));
          WakeAll:   sel[c] = 1'b1;
          default:   sel[c] = 1'b0;
        endcase
      end
    end
  end

  // Requests are always accepted once out of reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) ready_q <= 1'b0;
    else         ready_q <= 1'b1;
  end

  assign wake_req_ready_o = ready_q;
  assign inc              = wake_up_i | sel;

  for (genvar g = 0; g < NumCores; g++) begin : gen_core
    mempool_wake_up_core #(
      .PendWidth (PendWidth)
    ) i_core (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .inc_i      (inc[g]),
      .wfi_i      (core_wfi_i[g]),
      .wake_up_o  (wake_up_o[g]),
      .overflow_o (ovf[g])
    );
  end

  assign overflow_o = |ovf;

endmodule

// File: tb/tb_mempool_wake_up_unit.sv
// Directed bench for mempool_wake_up_unit with a pulse scoreboard.
// Build option MEMPOOL_WAKE_UP_COUNTER_EN changes the expected pulse counts.
module tb_mempool_wake_up_unit;

  localparam int NC = 256;
`ifdef MEMPOOL_WAKE_UP_COUNTER_EN
  localparam bit CntEn   = 1'b1;
  localparam int PendCap = 7;
`else
  localparam bit CntEn   = 1'b0;
  localparam int PendCap = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [NC-1:0] wake_up_i;
  logic          valid;
  logic          ready;
  logic [1:0]    mode;
  logic [7:0]    id;
  logic [NC-1:0] core_wfi;
  logic [NC-1:0] wake_up_o;
  logic          overflow;

  int cyc     = 0;
  int n_pass  = 0;
  int n_total = 0;
  bit mon_en  = 1'b0;

  typedef struct {
    int            cyc;
    logic [NC-1:0] vec;
  } exp_t;
  exp_t exp_q[$];

  mempool_wake_up_unit dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .wake_up_i        (wake_up_i),
    .wake_req_valid_i (valid),
    .wake_req_ready_o (ready),
    .wake_req_mode_i  (mode),
    .wake_req_id_i    (id),
    .core_wfi_i       (core_wfi),
    .wake_up_o        (wake_up_o),
    .overflow_o       (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic check_vec(input string tag, input logic [NC-1:0] obs, input logic [NC-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [NC-1:0] one_hot(input int c);
    logic [NC-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  task automatic expect_pulse(input int at, input logic [NC-1:0] v);
    exp_t e;
    e.cyc = at;
    e.vec = v;
    exp_q.push_back(e);
  endtask

  // Deliver n pulses to core c with the fastest legal WFI handshake, then
  // rearm once more and require that nothing further arrives.
  task automatic pulse_train(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      core_wfi[c] = 1'b1;
      expect_pulse(cyc + 1, one_hot(c));
      tick(2);
      core_wfi[c] = 1'b0;
      tick(1);
    end
    core_wfi[c] = 1'b1;
    tick(5);
    core_wfi[c] = 1'b0;
    tick(2);
  endtask

  // Every cycle: either the scheduled pulse vector or silence.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        check_vec("pulse", wake_up_o, e.vec);
      end else begin
        check_vec("no_pulse", wake_up_o, '0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NC-1:0] v;

    // reset with every input active
    rst_ni    = 1'b0;
    wake_up_i = '1;
    core_wfi  = '1;
    valid     = 1'b1;
    mode      = 2'd3;
    id        = 8'd0;
    tick(1);
    mon_en = 1'b1;
    tick(2);
    check_bit("rst_ready", ready, 1'b0);
    check_bit("rst_overflow", overflow, 1'b0);
    check_vec("rst_wake", wake_up_o, '0);

    rst_ni    = 1'b1;
    wake_up_i = '0;
    core_wfi  = '0;
    valid     = 1'b0;
    mode      = 2'd0;
    tick(1);
    check_bit("ready_after_release", ready, 1'b1);

    // single core request, latency 2
    core_wfi = one_hot(5);
    valid = 1'b1; mode = 2'd0; id = 8'd5;
    expect_pulse(cyc + 2, one_hot(5));
    tick(1);
    valid = 1'b0;
    tick(4);
    core_wfi = '0;
    tick(2);

    // external wake line, same latency
    core_wfi  = one_hot(6);
    wake_up_i = one_hot(6);
    expect_pulse(cyc + 2, one_hot(6));
    tick(1);
    wake_up_i = '0;
    tick(4);
    core_wfi = '0;
    tick(2);

    // tile 2 -> cores 8..11
    core_wfi = '1;
    valid = 1'b1; mode = 2'd1; id = 8'd2;
    v = '0; v[11:8] = '1;
    expect_pulse(cyc + 2, v);
    tick(1);
    valid = 1'b0;
    tick(4);
    core_wfi = '0;
    tick(2);

    // group 1 -> cores 64..127
    core_wfi = '1;
    valid = 1'b1; mode = 2'd2; id = 8'd1;
    v = '0; v[127:64] = '1;
    expect_pulse(cyc + 2, v);
    tick(1);
    valid = 1'b0;
    tick(4);
    core_wfi = '0;
    tick(2);

    // broadcast, id ignored
    core_wfi = '1;
    valid = 1'b1; mode = 2'd3; id = 8'd200;
    expect_pulse(cyc + 2, '1);
    tick(1);
    valid = 1'b0;
    tick(4);
    core_wfi = '0;
    tick(2);

    // three pending wakes on core 0 while awake
    valid = 1'b1; mode = 2'd0; id = 8'd0;
    tick(3);
    valid = 1'b0;
    tick(1);
    pulse_train(0, (CntEn ? 3 : 1));

    // eight wakes to core 1: four external, four software
    wake_up_i = one_hot(1);
    tick(4);
    wake_up_i = '0;
    valid = 1'b1; mode = 2'd0; id = 8'd1;
    tick(3);
    check_bit("overflow_before_8th", overflow, 1'b0);
    tick(1);
    valid = 1'b0;
    check_bit("overflow_after_8th", overflow, CntEn);
    pulse_train(1, PendCap);
    check_bit("overflow_sticky", overflow, CntEn);

    // increment during the PULSE cycle of core 3 leaves pend unchanged
    valid = 1'b1; mode = 2'd0; id = 8'd3;
    tick(2);
    valid = 1'b0;
    tick(1);
    core_wfi[3] = 1'b1;
    expect_pulse(cyc + 1, one_hot(3));
    tick(1);
    wake_up_i = one_hot(3);
    valid = 1'b1; mode = 2'd0; id = 8'd3;
    tick(1);
    wake_up_i   = '0;
    valid       = 1'b0;
    core_wfi[3] = 1'b0;
    tick(1);
    pulse_train(3, (CntEn ? 2 : 1));

    // out-of-range group and tile ids
    core_wfi = '1;
    valid = 1'b1; mode = 2'd2; id = 8'd7;
    tick(1);
    check_bit("ready_oor_group", ready, 1'b1);
    mode = 2'd1; id = 8'd64;
    tick(1);
    check_bit("ready_oor_tile", ready, 1'b1);
    valid = 1'b0;
    tick(4);
    core_wfi = '0;
    tick(2);

    // reset mid-operation drops pending wakes and the sticky flag
    valid = 1'b1; mode = 2'd0; id = 8'd2;
    tick(1);
    valid  = 1'b0;
    rst_ni = 1'b0;
    tick(1);
    check_bit("midrst_ready", ready, 1'b0);
    check_bit("midrst_overflow", overflow, 1'b0);
    rst_ni = 1'b1;
    tick(1);
    check_bit("midrst_ready_release", ready, 1'b1);
    core_wfi[2] = 1'b1;
    tick(4);
    core_wfi = '0;
    tick(2);

    check_bit("scoreboard_drained", (exp_q.size() == 0), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
